// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle logic/arith ops plus an iterative shift-add MULP.
// Optional macro MULT_HI_EN exposes the upper product half on ALUResultHi.
module alu_exec_unit #(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [3:0]        ALUOperation,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  output logic [N_BITS-1:0] ALUResult,
  output logic              Zero,
  output logic              Busy,
  output logic              Done
`ifdef MULT_HI_EN
  ,
  output logic [N_BITS-1:0] ALUResultHi
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0]       OP_AND   = 4'b0000;
  localparam logic [3:0]       OP_OR    = 4'b0001;
  localparam logic [3:0]       OP_NOR   = 4'b0010;
  localparam logic [3:0]       OP_ADD   = 4'b0011;
  localparam logic [3:0]       OP_SUB   = 4'b0100;
  localparam logic [3:0]       OP_INC   = 4'b0101;
  localparam logic [3:0]       OP_MULP  = 4'b0110;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [N_BITS-1:0]     mcand_r, mcand_nxt_s;
  logic [2*N_BITS-1:0]   acc_r, acc_nxt_s;
  logic [N_BITS:0]       sum_s;
  logic [N_BITS-1:0]     res_r, res_nxt_s;
  logic                  zero_r, busy_r, done_r;
  logic                  done_nxt_s;
  logic                  is_mulp_s;

  function automatic logic [N_BITS-1:0] alu_op(
    input logic [3:0]        op,
    input logic [N_BITS-1:0] a,
    input logic [N_BITS-1:0] b
  );
    logic [N_BITS-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_INC:  r = a + {{(N_BITS-1){1'b0}}, 1'b1};
      default: r = {N_BITS{1'b0}};
    endcase
    return r;
  endfunction

  assign is_mulp_s = (ALUOperation == OP_MULP);
  // Accumulator upper half plus multiplicand when the current multiplier bit is set; keeps carry.
  assign sum_s = {1'b0, acc_r[2*N_BITS-1:N_BITS]}
               + (acc_r[0] ? {1'b0, mcand_r} : {(N_BITS+1){1'b0}});

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start && is_mulp_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = MUL;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    res_nxt_s   = res_r;
    done_nxt_s  = 1'b0;
    cnt_nxt_s   = cnt_r;
    mcand_nxt_s = mcand_r;
    acc_nxt_s   = acc_r;
    case (state_r)
      IDLE: begin
        if (Start && is_mulp_s) begin
          mcand_nxt_s = A;
          acc_nxt_s   = {{N_BITS{1'b0}}, B};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (Start) begin
          res_nxt_s  = alu_op(ALUOperation, A, B);
          done_nxt_s = 1'b1;
        end else begin
          res_nxt_s  = res_r;
          done_nxt_s = 1'b0;
        end
      end
      MUL: begin
        // Shift right with the carry of the partial sum entering the top bit.
        acc_nxt_s = {sum_s, acc_r[N_BITS-1:1]};
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      FIN: begin
        res_nxt_s  = acc_r[N_BITS-1:0];
        done_nxt_s = 1'b1;
      end
      default: begin
        res_nxt_s  = res_r;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Result, flags and multiplier registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_r   <= {N_BITS{1'b0}};
      zero_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      mcand_r <= {N_BITS{1'b0}};
      acc_r   <= {(2*N_BITS){1'b0}};
    end else begin
      res_r   <= res_nxt_s;
      zero_r  <= (res_nxt_s == {N_BITS{1'b0}});
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= done_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mcand_r <= mcand_nxt_s;
      acc_r   <= acc_nxt_s;
    end
  end

  assign ALUResult = res_r;
  assign Zero      = zero_r;
  assign Busy      = busy_r;
  assign Done      = done_r;

`ifdef MULT_HI_EN
  logic [N_BITS-1:0] hi_r;

  // Upper product half, captured only on MULP completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= {N_BITS{1'b0}};
    end else if (state_r == FIN) begin
      hi_r <= acc_r[2*N_BITS-1:N_BITS];
    end else begin
      hi_r <= hi_r;
    end
  end

  assign ALUResultHi = hi_r;
`else
  // Upper product half stays internal to the accumulator.
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Busy;
  logic        Done;
`ifdef MULT_HI_EN
  logic [31:0] ALUResultHi;
`endif

  int errors = 0;
  int checks = 0;
  int n_cyc;
  int n_busy;
  int n_done;
  int first_done;

  alu_exec_unit #(.N_BITS(32), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .ALUOperation(ALUOperation),
    .A(A),
    .B(B),
    .ALUResult(ALUResult),
    .Zero(Zero),
    .Busy(Busy),
    .Done(Done)
`ifdef MULT_HI_EN
    ,
    .ALUResultHi(ALUResultHi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    ALUOperation = op;
    A = a;
    B = b;
  endtask

  // Tick until Done (bounded); returns ticks taken and Busy-high count including the current cycle.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = (Busy === 1'b1) ? 1 : 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (Done === 1'b1) break;
      if (Busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    ALUOperation = 4'b0000;
    A = 32'h0;
    B = 32'h0;
    tick();
    tick();
    check("rst_result", ALUResult, 32'h0);
    check("rst_zero", {31'b0, Zero}, 32'h1);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    reset = 1'b0;

    // ADD accepted at the first edge after reset release
    issue(4'b0011, 32'd7, 32'd5);
    tick();
    Start = 1'b0;
    check("add_result", ALUResult, 32'd12);
    check("add_zero", {31'b0, Zero}, 32'h0);
    check("add_done", {31'b0, Done}, 32'h1);
    check("add_busy", {31'b0, Busy}, 32'h0);
    tick();
    check("add_done_clr", {31'b0, Done}, 32'h0);
    check("add_hold", ALUResult, 32'd12);

    // Back-to-back single-cycle ops
    issue(4'b0100, 32'h10, 32'h10);
    tick();
    check("sub_result", ALUResult, 32'h0);
    check("sub_zero", {31'b0, Zero}, 32'h1);
    check("sub_done", {31'b0, Done}, 32'h1);
    issue(4'b0001, 32'h000000F0, 32'h0000000F);
    tick();
    check("or_result", ALUResult, 32'h000000FF);
    check("or_done", {31'b0, Done}, 32'h1);
    issue(4'b0101, 32'hFFFFFFFF, 32'h12345678);
    tick();
    check("inc_wrap", ALUResult, 32'h0);
    check("inc_zero", {31'b0, Zero}, 32'h1);
    issue(4'b0000, 32'hFF00FF00, 32'h0FF00FF0);
    tick();
    check("and_result", ALUResult, 32'h0F000F00);
    issue(4'b0010, 32'h00000000, 32'h00000000);
    tick();
    check("nor_result", ALUResult, 32'hFFFFFFFF);
    check("nor_zero", {31'b0, Zero}, 32'h0);
    Start = 1'b0;
    tick();

    // MULP 0x1234 * 0x100
    issue(4'b0110, 32'h00001234, 32'h00000100);
    tick();
    Start = 1'b0;
    check("mul_busy_e0", {31'b0, Busy}, 32'h1);
    check("mul_done_e0", {31'b0, Done}, 32'h0);
    check("mul_hold", ALUResult, 32'hFFFFFFFF);
    wait_done(n_cyc, n_busy);
    check("mul_latency", n_cyc, 32'd33);
    check("mul_busy_cycles", n_busy, 32'd33);
    check("mul_result", ALUResult, 32'h00123400);
    check("mul_zero", {31'b0, Zero}, 32'h0);
    check("mul_busy_end", {31'b0, Busy}, 32'h0);
`ifdef MULT_HI_EN
    check("mul_hi", ALUResultHi, 32'h0);
`endif
    tick();
    check("mul_done_clr", {31'b0, Done}, 32'h0);

    // Start pulsed mid-MULP is ignored
    issue(4'b0110, 32'd3, 32'd5);
    tick();
    Start = 1'b0;
    n_done = 0;
    first_done = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) issue(4'b0011, 32'd1, 32'd1);
      if (i == 6) Start = 1'b0;
      tick();
      if (Done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = i;
      end
    end
    check("ign_done_count", n_done, 32'd1);
    check("ign_done_cycle", first_done, 32'd33);
    check("ign_result", ALUResult, 32'd15);

    // MULP all-ones
    issue(4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    Start = 1'b0;
    wait_done(n_cyc, n_busy);
    check("ones_latency", n_cyc, 32'd33);
    check("ones_result", ALUResult, 32'h00000001);
    check("ones_zero", {31'b0, Zero}, 32'h0);
`ifdef MULT_HI_EN
    check("ones_hi", ALUResultHi, 32'hFFFFFFFE);
    issue(4'b0011, 32'd2, 32'd2);
    tick();
    Start = 1'b0;
    check("hi_kept", ALUResultHi, 32'hFFFFFFFE);
    check("hi_add", ALUResult, 32'd4);
`endif

    // Reset during MULP aborts
    issue(4'b0110, 32'd2, 32'd3);
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_pre", {31'b0, Busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_result", ALUResult, 32'h0);
    check("abort_zero", {31'b0, Zero}, 32'h1);
    check("abort_busy", {31'b0, Busy}, 32'h0);
    check("abort_done", {31'b0, Done}, 32'h0);
`ifdef MULT_HI_EN
    check("abort_hi", ALUResultHi, 32'h0);
`endif
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 32'd0);
    check("abort_idle", {31'b0, Busy}, 32'h0);

    // Unassigned opcodes give zero
    issue(4'b0011, 32'd5, 32'd6);
    tick();
    check("pre_undef", ALUResult, 32'd11);
    issue(4'b1001, 32'd5, 32'd6);
    tick();
    Start = 1'b0;
    check("undef_result", ALUResult, 32'h0);
    check("undef_zero", {31'b0, Zero}, 32'h1);
    check("undef_done", {31'b0, Done}, 32'h1);
    tick();
    check("undef_done_clr", {31'b0, Done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
